// File: rtl/tsp_run_ctrl_if.sv
// Bundle of the run controller's handshake and data signals: start/cont
// control, coordinate ROM read port, solver coordinate-file write port,
// solver kick/completion handshake and the status outputs.
// The slave modport is the controller; the master modport is whatever
// surrounds it (ROM, solver, host logic).
interface tsp_run_ctrl_if;
  logic        start;
  logic        cont;
  logic        rom_en;
  logic [5:0]  rom_addr;
  logic [7:0]  rom_x;
  logic [7:0]  rom_y;
  logic        city_we;
  logic [5:0]  city_idx;
  logic [7:0]  city_x;
  logic [7:0]  city_y;
  logic        solver_start;
  logic        solver_done;
  logic [31:0] solver_perf;
  logic [31:0] best_perf;
  logic [23:0] disp_val;
  logic        busy;
  logic        err_timeout;

  modport slave (
    input  start, cont, rom_x, rom_y, solver_done, solver_perf,
    output rom_en, rom_addr, city_we, city_idx, city_x, city_y,
           solver_start, best_perf, disp_val, busy, err_timeout
  );

  modport master (
    output start, cont, rom_x, rom_y, solver_done, solver_perf,
    input  rom_en, rom_addr, city_we, city_idx, city_x, city_y,
           solver_start, best_perf, disp_val, busy, err_timeout
  );
endinterface

// File: rtl/tsp_run_ctrl.sv
// Run controller for a TSP solver: copies the city coordinates from a
// synchronous ROM into the solver, kicks it, waits for completion (with a
// timeout), keeps the best tour length seen and periodically snapshots it
// for a slow display.
module tsp_run_ctrl #(
  parameter int unsigned N_CITY       = 64,
  parameter int unsigned REFRESH_BITS = 25,
  parameter int unsigned RUN_TIMEOUT  = 32'd16777216
) (
  input  logic          clk,
  input  logic          rst,
  tsp_run_ctrl_if.slave bus
);

  localparam int unsigned   LW         = $clog2(N_CITY + 1);
  localparam logic [LW-1:0] LOAD_LAST  = LW'(N_CITY);
  localparam logic [31:0]   TIMER_LAST = 32'(RUN_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_KICK,
    S_RUN,
    S_UPDATE
  } state_t;

  state_t                  state, state_nxt;
  logic [LW-1:0]           load_cnt;
  logic [31:0]             run_timer;
  logic [31:0]             perf_cap;
  logic [31:0]             best_perf;
  logic [REFRESH_BITS-1:0] refresh_cnt;
  logic [23:0]             disp_val;
  logic                    err_timeout;

  logic                    rom_en;
  logic [5:0]              rom_addr;
  logic                    city_we;
  logic [5:0]              city_idx;
  logic                    solver_start;
  logic                    run_expired;

  // The timer sits on its last allowed value: this RUN cycle is the final one.
  assign run_expired = (run_timer == TIMER_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and strobe decode. In LOAD, cycle k reads ROM entry k and
  // writes entry k-1, whose data the ROM returns one cycle after the read.
  // NOTE: every output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    rom_en       = 1'b0;
    rom_addr     = '0;
    city_we      = 1'b0;
    city_idx     = '0;
    solver_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (load_cnt != LOAD_LAST) begin
          rom_en   = 1'b1;
          rom_addr = 6'(load_cnt);
        end
        if (load_cnt != '0) begin
          city_we  = 1'b1;
          city_idx = 6'(load_cnt - LW'(1));
        end
        if (load_cnt == LOAD_LAST) state_nxt = S_KICK;
      end
      S_KICK: begin
        solver_start = 1'b1;
        state_nxt    = S_RUN;
      end
      S_RUN: begin
        // Completion wins over a timeout landing in the same cycle.
        if (bus.solver_done)  state_nxt = S_UPDATE;
        else if (run_expired) state_nxt = S_IDLE;
      end
      S_UPDATE: begin
        state_nxt = bus.cont ? S_KICK : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Load counter: cleared when a start is accepted, advances through LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               load_cnt <= '0;
    else if (state == S_IDLE && bus.start) load_cnt <= '0;
    else if (state == S_LOAD)              load_cnt <= load_cnt + LW'(1);
  end

  // Run timer: cleared by the kick, counts every RUN cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  run_timer <= '0;
    else if (state == S_KICK) run_timer <= '0;
    else if (state == S_RUN)  run_timer <= run_timer + 32'd1;
  end

  // Capture the solver result on completion, only while a run is active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  perf_cap <= '0;
    else if (state == S_RUN && bus.solver_done) perf_cap <= bus.solver_perf;
  end

  // Keep the strictly smaller tour length; ties leave the record untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          best_perf <= 32'hFFFF_FFFF;
    else if (state == S_UPDATE && perf_cap < best_perf) best_perf <= perf_cap;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                                  err_timeout <= 1'b0;
    else if (state == S_RUN && !bus.solver_done && run_expired) err_timeout <= 1'b1;
  end

  // Free-running refresh counter; the display snapshot is taken on its zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refresh_cnt <= '0;
      disp_val    <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + REFRESH_BITS'(1);
      if (refresh_cnt == '0) disp_val <= best_perf[23:0];
    end
  end

  assign bus.rom_en       = rom_en;
  assign bus.rom_addr     = rom_addr;
  assign bus.city_we      = city_we;
  assign bus.city_idx     = city_idx;
  assign bus.city_x       = city_we ? bus.rom_x : 8'd0;
  assign bus.city_y       = city_we ? bus.rom_y : 8'd0;
  assign bus.solver_start = solver_start;
  assign bus.best_perf    = best_perf;
  assign bus.disp_val     = disp_val;
  assign bus.busy         = (state != S_IDLE);
  assign bus.err_timeout  = err_timeout;

endmodule

// File: tb/tb_tsp_run_ctrl.sv
// Bench for tsp_run_ctrl: directed scenarios followed by randomized runs,
// checked against a cycle-count and min-tracking model of the controller.
module tb_tsp_run_ctrl;

  localparam int NC = 64;
  localparam int RB = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;

  tsp_run_ctrl_if bus ();

  tsp_run_ctrl #(
    .N_CITY      (NC),
    .REFRESH_BITS(RB),
    .RUN_TIMEOUT (TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  rom_xm [NC];
  logic [7:0]  rom_ym [NC];
  logic [31:0] exp_best;
  logic        exp_err;
  int          cyc;

  // Synchronous ROM: data for the address read in one cycle appears the next;
  // otherwise it returns junk.
  always @(posedge clk) begin
    if (bus.rom_en) begin
      bus.rom_x <= rom_xm[bus.rom_addr];
      bus.rom_y <= rom_ym[bus.rom_addr];
    end else begin
      bus.rom_x <= 8'($urandom);
      bus.rom_y <= 8'($urandom);
    end
  end

  // Clock edges since reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] strobes();
    return 32'({bus.rom_en, bus.city_we, bus.solver_start});
  endfunction

  task automatic do_reset();
    bus.start       = 1'b0;
    bus.cont        = 1'b0;
    bus.solver_done = 1'b0;
    bus.solver_perf = '0;
    rst = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_strobes", strobes(), 0);
    check("rst_addr", 32'({bus.rom_addr, bus.city_idx, bus.city_x, bus.city_y}), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_best", bus.best_perf, 32'hFFFF_FFFF);
    check("rst_disp", 32'(bus.disp_val), 0);
    check("rst_err", 32'(bus.err_timeout), 0);
    exp_best = 32'hFFFF_FFFF;
    exp_err  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Pulse start from IDLE and follow the load cycle by cycle up to the kick.
  // abort_at >= 0 pulses reset while rom_addr == abort_at.
  task automatic load_and_kick(input int abort_at);
    logic [2:0] exp_stb;
    @(negedge clk);
    bus.start = 1'b1;
    for (int c = 1; c <= NC + 2; c++) begin
      @(negedge clk);
      bus.start = (c == 10);  // ignored mid-load
      exp_stb = {c <= NC, (c >= 2) && (c <= NC + 1), c == NC + 2};
      check("ld_strobes", strobes(), 32'(exp_stb));
      check("ld_busy", 32'(bus.busy), 1);
      if (c <= NC) check("ld_addr", 32'(bus.rom_addr), 32'(c - 1));
      if (c >= 2 && c <= NC + 1) begin
        check("wr_idx", 32'(bus.city_idx), 32'(c - 2));
        check("wr_x", 32'(bus.city_x), 32'(rom_xm[c - 2]));
        check("wr_y", 32'(bus.city_y), 32'(rom_ym[c - 2]));
      end
      if (c == abort_at + 1) begin
        bus.start = 1'b0;
        rst = 1'b1;
        #1;
        check("ab_strobes", strobes(), 0);
        check("ab_busy", 32'(bus.busy), 0);
        check("ab_best", bus.best_perf, 32'hFFFF_FFFF);
        exp_best = 32'hFFFF_FFFF;
        exp_err  = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("ab_quiet", strobes(), 0);
        end
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check("ab_idle", 32'({bus.busy, bus.rom_en, bus.city_we, bus.solver_start}), 0);
        end
        return;
      end
    end
  endtask

  // Entered at the KICK cycle. The solver finishes in RUN cycle dly.
  task automatic run_once(input logic [31:0] perf, input int dly, input bit cont_v, input bit poke);
    bus.cont = cont_v;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      bus.start = poke && (i == 2);
      check("run_strobes", strobes(), 0);
      check("run_busy", 32'(bus.busy), 1);
    end
    @(negedge clk);
    bus.start       = 1'b0;
    bus.solver_done = 1'b1;
    bus.solver_perf = perf;
    @(negedge clk);
    bus.solver_done = 1'b0;
    bus.solver_perf = $urandom;
    check("upd_busy", 32'(bus.busy), 1);
    check("upd_strobes", strobes(), 0);
    if (perf < exp_best) exp_best = perf;
    @(negedge clk);
    check("best", bus.best_perf, exp_best);
    check("err", 32'(bus.err_timeout), 32'(exp_err));
    check("rekick", 32'(bus.solver_start), 32'(cont_v));
    check("busy_after", 32'(bus.busy), 32'(cont_v));
    check("no_reload", 32'({bus.rom_en, bus.city_we}), 0);
  endtask

  // Entered at the KICK cycle; the solver never answers.
  task automatic timeout_run();
    bus.cont = 1'($urandom_range(0, 1));
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      check("to_busy", 32'(bus.busy), 1);
      check("to_err_pre", 32'(bus.err_timeout), 32'(exp_err));
    end
    exp_err = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("to_err", 32'(bus.err_timeout), 1);
      check("to_idle", 32'(bus.busy), 0);
      check("to_best", bus.best_perf, exp_best);
      check("to_strobes", strobes(), 0);
    end
  endtask

  task automatic wait_disp(input logic [23:0] want);
    int waited = 0;
    while (bus.disp_val !== want && waited < (1 << RB) + 2) begin
      @(negedge clk);
      waited++;
    end
    check("disp_val", 32'(bus.disp_val), 32'(want));
    if (waited > 0) check("disp_phase", 32'(cyc % (1 << RB)), 1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cont_v;
    bit need_start;
    logic [31:0] perf;

    do_reset();

    // Completion pulses outside RUN are ignored.
    @(negedge clk);
    bus.solver_done = 1'b1;
    bus.solver_perf = 32'd5;
    @(negedge clk);
    bus.solver_done = 1'b0;
    @(negedge clk);
    check("idle_done_best", bus.best_perf, exp_best);
    check("idle_done_busy", 32'(bus.busy), 0);
    wait_disp(24'hFF_FFFF);

    // Directed load pattern and a single run.
    for (int i = 0; i < NC; i++) begin
      rom_xm[i] = 8'(i);
      rom_ym[i] = 8'(255 - i);
    end
    load_and_kick(-1);
    run_once(32'd1000, 4, 1'b0, 1'b0);
    wait_disp(24'd1000);

    // Continuous mode: 900, 950, 900, 800.
    do_reset();
    load_and_kick(-1);
    run_once(32'd900, 3, 1'b1, 1'b0);
    run_once(32'd950, 5, 1'b1, 1'b0);
    run_once(32'd900, 2, 1'b1, 1'b0);
    run_once(32'd800, 6, 1'b0, 1'b0);
    check("cont_final", bus.best_perf, 32'd800);

    // Completion on the timeout cycle wins; then a real timeout; then a
    // normal run with the flag still set.
    do_reset();
    load_and_kick(-1);
    run_once(32'd777, TO - 1, 1'b0, 1'b0);
    load_and_kick(-1);
    timeout_run();
    load_and_kick(-1);
    run_once(32'd600, 7, 1'b0, 1'b0);

    // Reset mid-load, then a run with start pulsed during RUN.
    do_reset();
    load_and_kick(30);
    load_and_kick(-1);
    run_once(32'd1234, 12, 1'b0, 1'b1);

    // Randomized runs with random ROM contents.
    need_start = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if (need_start) begin
        for (int k = 0; k < NC; k++) begin
          rom_xm[k] = 8'($urandom);
          rom_ym[k] = 8'($urandom);
        end
        load_and_kick(-1);
      end
      if ($urandom_range(0, 7) == 0) begin
        timeout_run();
        need_start = 1'b1;
      end else begin
        cont_v = 1'($urandom_range(0, 1));
        perf   = ($urandom_range(0, 3) == 0) ? exp_best : 32'($urandom_range(100, 5000));
        run_once(perf, $urandom_range(0, TO - 1), cont_v, 1'($urandom_range(0, 1)));
        need_start = !cont_v;
      end
    end
    wait_disp(exp_best[23:0]);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
